// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : loader_pkg
// Description : Shared types and constants for the boot-time instruction
//               loader: loader FSM state encoding, header width and
//               instruction geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

    // Width of the little-endian word-count header.
    localparam int CNT_W          = 16;
    // Bytes that make up one instruction word.
    localparam int BYTES_PER_WORD = 4;
    // Instruction width in bits.
    localparam int INSTR_W        = 32;
    // Byte-lane index width inside one instruction word.
    localparam int BIDX_W         = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        LEN_LO = 3'd0,
        LEN_HI = 3'd1,
        RECV   = 3'd2,
        WRITE  = 3'd3,
        CSUM   = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/instr_word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : instr_word_assembler
// Description : Collects bytes into a little-endian 32-bit instruction word.
//               Byte i of a word lands in bits [8i+7:8i].
// Ports       : clk, rst         - clock / synchronous active-high reset
//               i_byte_en        - a byte is accepted this cycle
//               i_byte           - accepted byte
//               i_clear          - loader consumed the word; drop word_ready
//               o_last_byte      - the next accepted byte completes the word
//               o_word_next      - word including the byte on i_byte
//               o_word_ready     - a complete word is waiting to be written
// Revision    : 1.0 - initial release
// ============================================================================
module instr_word_assembler
    import loader_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_byte_en,
    input  logic [7:0]         i_byte,
    input  logic               i_clear,
    output logic               o_last_byte,
    output logic [INSTR_W-1:0] o_word_next,
    output logic               o_word_ready
);

    logic [BIDX_W-1:0]  r_idx;
    logic [INSTR_W-1:0] r_word;
    logic               r_word_ready;
    logic [INSTR_W-1:0] w_word_next;

    // The merged word is combinational so the loader can register the full
    // instruction on the same edge that accepts the final byte.
    always_comb begin
        w_word_next = r_word;
        w_word_next[{r_idx, 3'b000} +: 8] = i_byte;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx        <= '0;
            r_word       <= '0;
            r_word_ready <= 1'b0;
        end else begin
            if (i_byte_en) begin
                r_word <= w_word_next;
                r_idx  <= r_idx + 1'b1;   // wraps to lane 0 after the last lane
                if (o_last_byte) begin
                    r_word_ready <= 1'b1;
                end
            end
            if (i_clear) begin
                r_word_ready <= 1'b0;
            end
        end
    end

    assign o_last_byte  = (r_idx == BIDX_W'(BYTES_PER_WORD - 1));
    assign o_word_next  = w_word_next;
    assign o_word_ready = r_word_ready;

endmodule
`default_nettype wire

// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
// Module      : instr_loader
// Description : Boot-time program loader upstream of core UP. Receives a
//               byte stream (16-bit word count, little-endian words, XOR
//               checksum byte), writes each word into instruction memory and
//               keeps the core in reset until a complete, checksum-clean
//               image has been loaded.
// Ports       : CLK, RST            - clock / synchronous active-high reset
//               BYTE_VALID/DATA     - byte source
//               BYTE_READY          - byte accepted when high with VALID
//               WRITE_INSTRUCTION   - one-cycle write strobe per word
//               INSTR_ADDR/DATA     - write address / instruction word
//               CORE_RST            - core reset, released on success
//               LOAD_DONE/LOAD_ERR  - sticky completion / failure flags
// Revision    : 1.0 - initial release
// ============================================================================
module instr_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               BYTE_VALID,
    input  logic [7:0]         BYTE_DATA,
    output logic               BYTE_READY,
    output logic               WRITE_INSTRUCTION,
    output logic [ADDR_W-1:0]  INSTR_ADDR,
    output logic [INSTR_W-1:0] INSTR_DATA,
    output logic               CORE_RST,
    output logic               LOAD_DONE,
    output logic               LOAD_ERR
);

    // Largest legal image, in words.
    localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;

    loader_state_t      r_state;
    loader_state_t      w_state_next;
    logic [CNT_W-1:0]   r_count;
    // One extra bit so a full-capacity image does not wrap the index.
    logic [ADDR_W:0]    r_word_idx;
    logic [7:0]         r_xor;
    logic               r_byte_ready;
    logic               r_write;
    logic [ADDR_W-1:0]  r_instr_addr;
    logic [INSTR_W-1:0] r_instr_data;
    logic               r_core_rst;
    logic               r_done;
    logic               r_err;

    logic               w_accept;
    logic [CNT_W-1:0]   w_count_full;
    logic               w_last_word;
    logic               w_last_byte;
    logic               w_word_ready;
    logic [INSTR_W-1:0] w_word_next;

    assign w_accept     = BYTE_VALID && r_byte_ready;
    assign w_count_full = {BYTE_DATA, r_count[7:0]};
    assign w_last_word  = ((32'(r_word_idx) + 32'd1) == 32'(r_count));

    instr_word_assembler u_asm (
        .clk          (CLK),
        .rst          (RST),
        .i_byte_en    (w_accept && (r_state == RECV)),
        .i_byte       (BYTE_DATA),
        .i_clear      (r_state == WRITE),
        .o_last_byte  (w_last_byte),
        .o_word_next  (w_word_next),
        .o_word_ready (w_word_ready)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            LEN_LO: begin
                if (w_accept) w_state_next = LEN_HI;
            end
            LEN_HI: begin
                if (w_accept) begin
                    if (32'(w_count_full) > MAX_WORDS) begin
                        w_state_next = ERR;
                    end else if (w_count_full == '0) begin
                        w_state_next = CSUM;
                    end else begin
                        w_state_next = RECV;
                    end
                end
            end
            RECV: begin
                if (w_accept && w_last_byte) w_state_next = WRITE;
            end
            WRITE: begin
                if (w_word_ready) w_state_next = w_last_word ? CSUM : RECV;
            end
            CSUM: begin
                if (w_accept) w_state_next = (BYTE_DATA == r_xor) ? DONE : ERR;
            end
            DONE, ERR: begin
                w_state_next = r_state;
            end
            default: begin
                w_state_next = LEN_LO;
            end
        endcase
    end

    // Outputs are registered from the next state so each one reflects the
    // state it belongs to in the same cycle the FSM occupies that state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= LEN_LO;
            r_count      <= '0;
            r_word_idx   <= '0;
            r_xor        <= '0;
            r_byte_ready <= 1'b0;
            r_write      <= 1'b0;
            r_instr_addr <= '0;
            r_instr_data <= '0;
            r_core_rst   <= 1'b1;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_state_next;

            if (w_accept && (r_state == LEN_LO)) r_count[7:0]       <= BYTE_DATA;
            if (w_accept && (r_state == LEN_HI)) r_count[CNT_W-1:8] <= BYTE_DATA;

            // The checksum byte itself is not part of the running XOR.
            if (w_accept && (r_state != CSUM)) r_xor <= r_xor ^ BYTE_DATA;

            if ((r_state == WRITE) && w_word_ready) r_word_idx <= r_word_idx + 1'b1;

            if ((r_state == RECV) && (w_state_next == WRITE)) begin
                r_instr_addr <= r_word_idx[ADDR_W-1:0];
                r_instr_data <= w_word_next;
            end

            r_write      <= (w_state_next == WRITE);
            r_byte_ready <= (w_state_next == LEN_LO) || (w_state_next == LEN_HI) ||
                            (w_state_next == RECV)   || (w_state_next == CSUM);
            r_core_rst   <= (w_state_next != DONE);
            r_done       <= (w_state_next == DONE);
            r_err        <= (w_state_next == ERR);
        end
    end

    assign BYTE_READY        = r_byte_ready;
    assign WRITE_INSTRUCTION = r_write;
    assign INSTR_ADDR        = r_instr_addr;
    assign INSTR_DATA        = r_instr_data;
    assign CORE_RST          = r_core_rst;
    assign LOAD_DONE         = r_done;
    assign LOAD_ERR          = r_err;

endmodule
`default_nettype wire

// File: doc/instr_loader.md
Name: instr_loader

Overview:
Boot-time program loader that sits directly upstream of the processor core UP.
- Accepts a byte stream over a valid/ready interface: a 16-bit word count, the program words, then a checksum byte.
- Assembles little-endian 32-bit instructions and writes each one into UP's instruction memory through the instruction write port.
- Holds the core in reset until the whole image is loaded and the checksum matches.

Parameters:
ADDR_W, 8, instruction memory word-address width; capacity is 2**ADDR_W words.
CNT_W, 16, width of the word-count header; fixed at 16, exposed for package use.

Ports:
CLK  input  1  system clock; all logic on rising edge.
RST  input  1  synchronous, active-high reset.
BYTE_VALID  input  1  source presents a byte.
BYTE_DATA  input  8  byte payload.
BYTE_READY  output  1  loader accepts the byte this cycle.
WRITE_INSTRUCTION  output  1  instruction-memory write enable, one-cycle pulse per word.
INSTR_ADDR  output  ADDR_W  word address for the write.
INSTR_DATA  output  32  instruction word for the write.
CORE_RST  output  1  reset to UP; high until a successful load.
LOAD_DONE  output  1  sticky; image loaded and checksum OK.
LOAD_ERR  output  1  sticky; checksum mismatch or oversize image.

Behaviour:
- One clock domain (CLK). RST is synchronous and active-high.
- All outputs are registered.
- Reset values:
  - BYTE_READY=0, WRITE_INSTRUCTION=0.
  - INSTR_ADDR=0, INSTR_DATA=0.
  - CORE_RST=1, LOAD_DONE=0, LOAD_ERR=0.
  - State=LEN_LO, word index=0, byte index=0, running XOR=0.
- A byte transfers on any cycle with BYTE_VALID && BYTE_READY. BYTE_VALID may drop at any time with no penalty.
- BYTE_READY=1 in LEN_LO, LEN_HI, RECV and CSUM (from the first cycle after RST falls); 0 in WRITE, DONE and ERR.
- Every accepted byte, including the length bytes and excluding the checksum byte, is XORed into the running checksum.
- States:
  - LEN_LO: accept byte -> count[7:0]; go to LEN_HI.
  - LEN_HI: accept byte -> count[15:8]. If count > 2**ADDR_W -> ERR. If count == 0 -> CSUM. Otherwise -> RECV.
  - RECV: byte i (0..3) -> word[8i+7:8i], little-endian. On the 4th byte, go to WRITE.
  - WRITE: WRITE_INSTRUCTION=1 for exactly one cycle, with INSTR_ADDR=word index and INSTR_DATA=assembled word. Word index then increments. If word index+1 == count -> CSUM, else -> RECV.
  - CSUM: accept byte. If it equals the running XOR -> DONE, else -> ERR.
  - DONE: CORE_RST=0 and LOAD_DONE=1 starting the cycle after the checksum byte is accepted. Terminal until RST.
  - ERR: LOAD_ERR=1 and CORE_RST held at 1. Terminal until RST.
- Hold behaviour: INSTR_ADDR and INSTR_DATA hold their last written values outside WRITE. No write is ever issued with an address >= count.
- Latency:
  - 4th word byte accepted -> write pulse on the next cycle.
  - Each word costs at least 5 cycles.
- Full capacity: count == 2**ADDR_W is legal. The last write goes to address 2**ADDR_W-1, and the word index must not wrap before CSUM.
- RST mid-load: all state returns to reset values and CORE_RST rises. Instruction memory contents are not cleared by this block. A partially accepted word is discarded.
- RST while in DONE: CORE_RST returns to 1 and the loader awaits a fresh image.

Decomposition:
- Package loader_pkg:
  - State enum: LEN_LO, LEN_HI, RECV, WRITE, CSUM, DONE, ERR.
  - CNT_W constant.
  - BYTES_PER_WORD=4.
  - Instruction width 32.
- One natural sub-module, instr_word_assembler:
  - 2-bit byte index.
  - 32-bit little-endian shift/insert register.
  - word_ready flag, cleared by the loader on WRITE.
- The FSM, counters and checksum stay in instr_loader.

Test Plan:
- Single word: bytes 01 00 13 00 00 00 12 -> one pulse with INSTR_ADDR=0, INSTR_DATA=0x00000013. LOAD_DONE=1 and CORE_RST=0 the cycle after byte 0x12.
- Empty image: bytes 00 00 00 -> no WRITE_INSTRUCTION pulses; DONE, CORE_RST=0.
- Bad checksum: bytes 01 00 13 00 00 00 13 -> one write at address 0, then LOAD_ERR=1, CORE_RST stays 1, BYTE_READY=0 thereafter.
- Oversize: ADDR_W=8, bytes 01 01 -> ERR immediately after the 2nd byte; zero writes. Also load exactly 256 words -> last write at address 0xFF, DONE.
- Backpressure: 3-word image with randomly gapped BYTE_VALID and a byte presented during a WRITE cycle -> byte held, not lost. Writes land at addresses 0, 1, 2 with the correct words; same end state as the gapless run.
- Mid-load reset: pulse RST after 2 bytes of word 1 -> CORE_RST=1 and outputs at reset values. A fresh single-word image then loads correctly at address 0.
